// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch-side redirect logic: state encoding, PC constants
// and the bit positions of the pipeline-register flush vector.
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC           = 4;

    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;
    localparam int FLUSH_W     = 3;

    function automatic logic misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: applies MEM-stage branch and ID-stage jump redirects,
// drives pipeline flushes, latches misaligned targets into HALT, counts branches.
//
// state | meaning
// BOOT  | single post-reset cycle, fetch not yet valid, PC at RESET_PC
// RUN   | normal fetch; branch > jump > stall > sequential
// HALT  | misaligned redirect seen; PC frozen until reset
module pc_redirect_unit
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              mem_branch,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_valid,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              addr_err,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
);

    pc_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                addr_err_q;
    logic                err_set;
    logic                br_bad, jmp_go, jmp_bad;
    logic [FLUSH_W-1:0]  flush_vec;
    logic                en_taken, en_nottaken;

    // A jump alongside a taken branch is on the wrong path, so it never qualifies.
    assign br_bad  = take_branch && misaligned(branch_target[1:0]);
    assign jmp_go  = jump_req && !stall && !take_branch;
    assign jmp_bad = jmp_go && misaligned(jump_target[1:0]);

    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (err_set) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (br_bad || jmp_bad) begin
                    state_d = HALT;
                end else if (take_branch) begin
                    pc_d = branch_target;
                end else if (jmp_go) begin
                    pc_d = jump_target;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = 1'b0;
        flush_vec   = '0;
        err_set     = 1'b0;
        if (rst_n && (state_q == RUN)) begin
            fetch_valid = 1'b1;
            err_set     = br_bad || jmp_bad;
            if (take_branch && !br_bad) begin
                flush_vec[FLUSH_IFID]  = 1'b1;
                flush_vec[FLUSH_IDEX]  = 1'b1;
                flush_vec[FLUSH_EXMEM] = 1'b1;
            end else if (jmp_go && !jmp_bad) begin
                flush_vec[FLUSH_IFID] = 1'b1;
            end
        end
    end

    assign flush_ifid  = flush_vec[FLUSH_IFID];
    assign flush_idex  = flush_vec[FLUSH_IDEX];
    assign flush_exmem = flush_vec[FLUSH_EXMEM];
    assign pc_out      = pc_q;
    assign addr_err    = addr_err_q;

    // Misaligned taken branches still count as taken.
    assign en_taken    = (state_q == RUN) && mem_branch && take_branch;
    assign en_nottaken = (state_q == RUN) && mem_branch && !take_branch;

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_taken),
        .cnt   (taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_nottaken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_nottaken),
        .cnt   (nottaken_cnt)
    );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a behavioural model pushes expected post-edge
// state into a scoreboard queue, popped and compared after each clock edge.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, mem_branch, take_branch, jump_req;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus4;
    logic        fetch_valid, flush_ifid, flush_idex, flush_exmem, addr_err;
    logic [15:0] taken_cnt, nottaken_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        err;
        logic [15:0] tk;
        logic [15:0] nt;
    } exp_t;

    exp_t sb[$];

    int          m_st;
    logic [31:0] m_pc;
    logic        m_err;
    logic [15:0] m_tk, m_nt;

    pc_redirect_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .mem_branch    (mem_branch),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .jump_req      (jump_req),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .flush_exmem   (flush_exmem),
        .addr_err      (addr_err),
        .taken_cnt     (taken_cnt),
        .nottaken_cnt  (nottaken_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_pc  = 32'h0;
        m_err = 1'b0;
        m_tk  = 16'h0;
        m_nt  = 16'h0;
    endtask

    // One clock: drive, check combinational outputs, predict, clock, pop and compare.
    task automatic cycle(input logic stl, input logic mb, input logic tb, input logic [31:0] bt,
                         input logic jr, input logic [31:0] jt);
        logic [2:0]  ef;
        logic [1:0]  blo, jlo;
        exp_t        e;
        stall = stl; mem_branch = mb; take_branch = tb; branch_target = bt;
        jump_req = jr; jump_target = jt;
        #1;
        blo = bt[1:0];
        jlo = jt[1:0];
        ef  = 3'b000;
        if (m_st == 1) begin
            if (tb && blo == 2'b00)                 ef = 3'b111;
            else if (!tb && jr && !stl && jlo == 2'b00) ef = 3'b001;
        end
        chk("flush_ifid",  {31'b0, flush_ifid},  {31'b0, ef[0]});
        chk("flush_idex",  {31'b0, flush_idex},  {31'b0, ef[1]});
        chk("flush_exmem", {31'b0, flush_exmem}, {31'b0, ef[2]});
        chk("fetch_valid_now", {31'b0, fetch_valid}, {31'b0, (m_st == 1)});
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (mb) begin
                if (tb) begin
                    if (m_tk != 16'hFFFF) m_tk = m_tk + 16'd1;
                end else begin
                    if (m_nt != 16'hFFFF) m_nt = m_nt + 16'd1;
                end
            end
            if (tb && blo != 2'b00) begin
                m_err = 1'b1; m_st = 2;
            end else if (tb) begin
                m_pc = bt;
            end else if (jr && !stl) begin
                if (jlo != 2'b00) begin
                    m_err = 1'b1; m_st = 2;
                end else begin
                    m_pc = jt;
                end
            end else if (!stl) begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.fv = (m_st == 1); e.err = m_err; e.tk = m_tk; e.nt = m_nt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pc_out",       pc_out,                  e.pc);
            chk("fetch_valid",  {31'b0, fetch_valid},    {31'b0, e.fv});
            chk("addr_err",     {31'b0, addr_err},       {31'b0, e.err});
            chk("taken_cnt",    {16'b0, taken_cnt},      {16'b0, e.tk});
            chk("nottaken_cnt", {16'b0, nottaken_cnt},   {16'b0, e.nt});
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        stall = 1'b0; mem_branch = 1'b1; take_branch = 1'b1; branch_target = 32'h40;
        jump_req = 1'b1; jump_target = 32'h100;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pc",       pc_out,                32'h0);
        chk("rst_fv",       {31'b0, fetch_valid},  32'h0);
        chk("rst_err",      {31'b0, addr_err},     32'h0);
        chk("rst_tk",       {16'b0, taken_cnt},    32'h0);
        chk("rst_nt",       {16'b0, nottaken_cnt}, 32'h0);
        chk("rst_flush",    {29'b0, flush_ifid, flush_idex, flush_exmem}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
        chk("boot_pc", pc_out, 32'h0);
        // Branch request in BOOT must neither flush, redirect nor count.
        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("first_fetch_pc", pc_out, 32'h0);
        chk("first_fetch_fv", {31'b0, fetch_valid}, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq_pc4", pc_out, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq_pc8", pc_out, 32'h8);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("at_0x10", pc_out, 32'h10);

        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("branch_pc", pc_out, 32'h40);
        chk("branch_tk", {16'b0, taken_cnt}, 32'h1);

        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        chk("jump_pc", pc_out, 32'h20);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold", pc_out, 32'h20);
        cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("branch_over_stall", pc_out, 32'h80);

        cycle(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
        chk("branch_beats_jump", pc_out, 32'h200);
        chk("tk_after_3", {16'b0, taken_cnt}, 32'h3);

        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
        chk("stalled_bad_jump_err", {31'b0, addr_err}, 32'h0);

        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("uncounted_branch_tk", {16'b0, taken_cnt}, 32'h3);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pc_wrap", pc_out, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("nt_one", {16'b0, nottaken_cnt}, 32'h1);

        cycle(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
        chk("halt_err", {31'b0, addr_err}, 32'h1);
        chk("halt_fv",  {31'b0, fetch_valid}, 32'h0);
        chk("halt_pc",  pc_out, 32'h4);
        chk("halt_tk",  {16'b0, taken_cnt}, 32'h4);
        cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        chk("halt_frozen", pc_out, 32'h4);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc",  pc_out, 32'h0);
        chk("async_rst_err", {31'b0, addr_err}, 32'h0);
        chk("async_rst_tk",  {16'b0, taken_cnt}, 32'h0);
        chk("async_rst_fv",  {31'b0, fetch_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("post_rst_pc", pc_out, 32'h0);

        for (int i = 0; i < 65536 + 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("nt_saturated", {16'b0, nottaken_cnt}, 32'h0000_FFFF);
        chk("tk_zero",      {16'b0, taken_cnt},    32'h0);

        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
        chk("bad_jump_err", {31'b0, addr_err}, 32'h1);
        chk("bad_jump_fv",  {31'b0, fetch_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side consumer of the branch decision in the Phase 3 pipelined MIPS core. Owns the program counter and applies control-flow redirects:
- the registered taken-branch select from the MEM stage (zero AND branch);
- unconditional jumps resolved in ID.

Drives the pipeline-register flush lines and the load-use stall hold. Latches misaligned redirect targets into a sticky error/halt state. Keeps taken/not-taken branch statistics for the bench.

## Interface
Parameters:
- ADDR_W, 32, PC and target width
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit hold; PC and IF/ID keep their value
- mem_branch  in  1  MEM-stage instruction is a conditional branch
- take_branch  in  1  MEM-stage branch decision (zero AND branch)
- branch_target  in  ADDR_W  MEM-stage branch target
- jump_req  in  1  ID-stage unconditional jump
- jump_target  in  ADDR_W  ID-stage jump target
- pc_out  out  ADDR_W  current fetch address, registered
- pc_plus4  out  ADDR_W  pc_out + 4, combinational
- fetch_valid  out  1  fetch address is architecturally valid
- flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous clears for the pipeline registers
- addr_err  out  1  sticky misaligned-target error
- taken_cnt, nottaken_cnt  out  CNT_W each  saturating branch statistics

Reset behaviour is fixed: one clock; reset is asynchronous and active-low.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT:
  - lasts exactly one cycle; fetch_valid=0; PC holds RESET_PC.
  - next state RUN.
- RUN, evaluated in priority order each cycle:
  1. take_branch=1 and branch_target[1:0]!=0: addr_err<=1, next HALT, PC unchanged, no flush.
  2. take_branch=1: PC<=branch_target; flush_ifid=flush_idex=flush_exmem=1 this cycle. stall is ignored, because the branch is older than any hazard.
  3. jump_req=1 and stall=0:
     - if jump_target[1:0]!=0: error as in rule 1;
     - otherwise PC<=jump_target and flush_ifid=1 only.
  4. stall=1: PC held, no flush.
  5. Otherwise: PC<=PC+4.
- A jump in the same cycle as a taken branch is discarded, because it is on the wrong path.
- HALT:
  - PC frozen; fetch_valid=0; all flushes 0.
  - addr_err stays 1; exit only by reset.
- Statistics:
  - in RUN, when mem_branch=1, exactly one counter increments: taken_cnt if take_branch=1, else nottaken_cnt.
  - A misaligned taken branch still counts as taken.
  - Counters saturate at all-ones and never wrap.
  - take_branch=1 with mem_branch=0 is treated as taken but not counted.
- Arithmetic:
  - PC+4 is modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0x0000_0000 with no error.
  - Targets are used unmodified.

## Timing
- Reset values: pc_out=RESET_PC, fetch_valid=0, addr_err=0, taken_cnt=nottaken_cnt=0.
- Flush outputs are combinational from state and inputs, and are forced to 0 while rst_n=0 and in BOOT/HALT.
- Redirect latency: a taken branch in cycle N gives pc_out=target in cycle N+1. Flushes are high in cycle N only, so the three wrong-path instructions die at edge N.
- Jump latency: one bubble; pc_out=jump_target in cycle N+1.
- fetch_valid is 1 in every RUN cycle, including stalled ones.
- Counters update at the same edge as the PC.
- Reset mid-operation returns to BOOT within the same cycle (asynchronous). The first valid fetch is RESET_PC in the cycle after BOOT.

## Structure
- Shared package, pipeline_pkg:
  - state enum: BOOT/RUN/HALT
  - RESET_PC default
  - PC_INC=4
  - flush-vector field positions (IFID/IDEX/EXMEM)
- One natural sub-module: sat_counter (CNT_W, enable, saturate), instantiated twice.
- The next-PC mux and the state register stay in the top module.

## Test plan
- Reset release → one cycle with fetch_valid=0 and pc_out=0; then pc_out steps 0x0, 0x4, 0x8 each cycle.
- PC=0x10, take_branch=1, target=0x40 → three flushes high that cycle; next cycle pc_out=0x40; taken_cnt=1.
- stall=1 held 3 cycles at PC=0x20 → pc_out stays 0x20. take_branch=1, target=0x80 arriving while stall=1 → pc_out=0x80 next cycle.
- jump_req=1 with take_branch=1 on the same cycle, jump_target=0x100, branch_target=0x200 → pc_out=0x200; only the branch flush pattern; jump lost.
- take_branch=1, target=0x42 → addr_err=1, HALT, fetch_valid=0, pc_out frozen. Subsequent jumps and branches are ignored until rst_n pulses low.
- 2^CNT_W+5 not-taken branches (mem_branch=1, take_branch=0) → nottaken_cnt=0xFFFF, taken_cnt=0. PC at 0xFFFF_FFFC with no branch wraps to 0x0.
